// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate generator: format enum, RV opcodes, buffered payload.
// Payload carries an optional branch/jump target when IMM_GEN_TARGET_EN is defined.
package imm_gen_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SH  = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  // Fields sized for the widest datapath; narrower builds leave the upper bits at zero.
  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    fmt_e                fmt;
    logic [MAX_XLEN-1:0] pc;
    logic                illegal;
`ifdef IMM_GEN_TARGET_EN
    logic [MAX_XLEN-1:0] target;
`endif
  } imm_payload_t;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register drives the output, skid absorbs
// one extra beat during a stall so in_ready stays a pure register output.
module imm_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         push, pop;

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    push       = in_valid && !skid_vld_q;
    pop        = main_vld_q && out_ready;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (pop) begin
        if (skid_vld_q) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = 1'b0;
        end
      end
      // push implies skid empty, so it lands in main whenever main is free after this cycle
      if (push) begin
        if (!main_vld_q || pop) begin
          main_vld_d = 1'b1;
          main_d     = in_data;
        end else begin
          skid_vld_d = 1'b1;
          skid_d     = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator: opcode-driven decode into a 2-entry skid buffer,
// plus a saturating illegal-opcode counter. IMM_GEN_TARGET_EN adds out_target (pc+imm).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_fmt,
  output logic [XLEN-1:0]      out_pc,
  output logic                 out_illegal,
`ifdef IMM_GEN_TARGET_EN
  output logic [XLEN-1:0]      out_target,
`endif
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]           opc;
  logic [2:0]           f3;
  logic [MAX_XLEN-1:0]  imm64;
  fmt_e                 fmt;
  logic                 ill;
  imm_payload_t         pay_in, pay_out;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];

  always_comb begin
    imm64 = '0;
    fmt   = FMT_ILL;
    ill   = 1'b1;
    case (opc)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
        fmt   = FMT_I;
        ill   = 1'b0;
      end
      OPC_OP_IMM: begin
        ill = 1'b0;
        if (is_shift(f3)) begin
          fmt   = FMT_SH;
          imm64 = RV64 ? {58'b0, in_instr[25:20]} : {59'b0, in_instr[24:20]};
        end else begin
          fmt   = FMT_I;
          imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OPC_OP_IMM32: if (RV64) begin
        ill = 1'b0;
        if (is_shift(f3)) begin
          fmt   = FMT_SH;
          imm64 = {59'b0, in_instr[24:20]};
        end else begin
          fmt   = FMT_I;
          imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OPC_STORE: begin
        imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        fmt   = FMT_S;
        ill   = 1'b0;
      end
      OPC_BRANCH: begin
        imm64 = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        fmt   = FMT_B;
        ill   = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
        fmt   = FMT_U;
        ill   = 1'b0;
      end
      OPC_JAL: begin
        imm64 = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        fmt   = FMT_J;
        ill   = 1'b0;
      end
      OPC_OP: begin
        fmt = FMT_R;
        ill = 1'b0;
      end
      OPC_OP32: if (RV64) begin
        fmt = FMT_R;
        ill = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    pay_in         = '0;
    pay_in.imm     = MAX_XLEN'(imm64[XLEN-1:0]);
    pay_in.fmt     = fmt;
    pay_in.pc      = MAX_XLEN'(in_pc);
    pay_in.illegal = ill;
`ifdef IMM_GEN_TARGET_EN
    if (fmt == FMT_B || fmt == FMT_J || opc == OPC_AUIPC)
      pay_in.target = MAX_XLEN'(in_pc + imm64[XLEN-1:0]);
`endif
  end

  imm_skid_buf #(.W($bits(imm_payload_t))) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign out_imm     = pay_out.imm[XLEN-1:0];
  assign out_fmt     = pay_out.fmt;
  assign out_pc      = pay_out.pc[XLEN-1:0];
  assign out_illegal = pay_out.illegal;
`ifdef IMM_GEN_TARGET_EN
  assign out_target  = pay_out.target[XLEN-1:0];
`endif

  // Upper payload/decode bits are structurally zero or unused in a 32-bit build.
  generate if (XLEN < MAX_XLEN) begin : g_unused
    logic unused_hi;
`ifdef IMM_GEN_TARGET_EN
    assign unused_hi = ^{imm64[MAX_XLEN-1:XLEN], pay_out.imm[MAX_XLEN-1:XLEN],
                         pay_out.pc[MAX_XLEN-1:XLEN], pay_out.target[MAX_XLEN-1:XLEN]};
`else
    assign unused_hi = ^{imm64[MAX_XLEN-1:XLEN], pay_out.imm[MAX_XLEN-1:XLEN],
                         pay_out.pc[MAX_XLEN-1:XLEN]};
`endif
  end endgenerate

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (out_valid && out_ready && pay_out.illegal && ill_cnt_q != {ILL_CNT_W{1'b1}})
      ill_cnt_d = ill_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ill_cnt_q <= '0;
    else       ill_cnt_q <= ill_cnt_d;
  end

  assign ill_count = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit main instance plus a 64-bit and a 2-bit-counter
// instance sharing the same stimulus. Define IMM_GEN_TARGET_EN to also check out_target.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_pc;
  logic [2:0]  out_fmt;
  logic [15:0] ill_count;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_pc64;
  logic [2:0]  out_fmt64;
  logic [15:0] ill_count64;

  logic        in_ready_w2, out_valid_w2, out_illegal_w2;
  logic [31:0] out_imm_w2, out_pc_w2;
  logic [2:0]  out_fmt_w2;
  logic [1:0]  ill_count_w2;
`ifdef IMM_GEN_TARGET_EN
  logic [31:0] out_target, out_target_w2;
  logic [63:0] out_target64;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .ILL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_pc(out_pc), .out_illegal(out_illegal),
`ifdef IMM_GEN_TARGET_EN
    .out_target(out_target),
`endif
    .ill_count(ill_count));

  imm_gen_pipe #(.XLEN(64), .ILL_CNT_W(16)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc({32'b0, in_pc}), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_pc(out_pc64), .out_illegal(out_illegal64),
`ifdef IMM_GEN_TARGET_EN
    .out_target(out_target64),
`endif
    .ill_count(ill_count64));

  imm_gen_pipe #(.XLEN(32), .ILL_CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w2),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_w2), .out_ready(out_ready),
    .out_imm(out_imm_w2), .out_fmt(out_fmt_w2), .out_pc(out_pc_w2), .out_illegal(out_illegal_w2),
`ifdef IMM_GEN_TARGET_EN
    .out_target(out_target_w2),
`endif
    .ill_count(ill_count_w2));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One-beat transfer with out_ready=1; checks the 32-bit instance one cycle after accept.
  task automatic send(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] exp_imm, input fmt_e exp_fmt);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_imm"},   out_imm, exp_imm);
    chk({tag, "_fmt"},   out_fmt, exp_fmt);
    chk({tag, "_pc"},    out_pc, pc);
    chk({tag, "_ill"},   out_illegal, exp_fmt == FMT_ILL);
  endtask

  initial begin
    int acc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_fmt", out_fmt, 0);
    chk("rst_ill", out_illegal, 0);
    chk("rst_cnt", ill_count, 0);
    @(negedge clk) reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    send("addi_m1", 32'hFFF00093, 32'h10, 32'hFFFFFFFF, FMT_I);
    send("beq_m4",  32'hFE000EE3, 32'h14, 32'hFFFFFFFC, FMT_B);
    send("jal_800", 32'h001000EF, 32'h18, 32'h00000800, FMT_J);
    send("lui",     32'h123452B7, 32'h1C, 32'h12345000, FMT_U);
    send("slli5",   32'h00509093, 32'h20, 32'd5,        FMT_SH);
    send("srai3",   32'h4030D093, 32'h24, 32'd3,        FMT_SH);
    chk("srai3_64", out_imm64, 64'd3);
    send("slli63",  32'h03F09093, 32'h28, 32'd31,       FMT_SH);
    chk("slli63_64", out_imm64, 64'd63);
    send("sw8",     32'h00112423, 32'h2C, 32'd8,        FMT_S);
    send("add",     32'h002081B3, 32'h30, 32'd0,        FMT_R);
    send("lui_neg", 32'h800002B7, 32'h34, 32'h80000000, FMT_U);
    chk("lui_neg_64", out_imm64, 64'hFFFFFFFF80000000);
    send("op32_rv32", 32'h0000003B, 32'h38, 32'd0,      FMT_ILL);
    chk("op32_rv64_fmt", out_fmt64, FMT_R);
    chk("op32_rv64_ill", out_illegal64, 0);
    send("ill_a",   32'h0000007F, 32'h3C, 32'd0,        FMT_ILL);
    send("ill_b",   32'h0000007F, 32'h40, 32'd0,        FMT_ILL);
    @(negedge clk);
    chk("cnt3", ill_count, 3);
    chk("cnt3_64", ill_count64, 2);
    send("ill_c",   32'h0000007F, 32'h44, 32'd0,        FMT_ILL);
    send("ill_d",   32'h0000007F, 32'h48, 32'd0,        FMT_ILL);
    @(negedge clk);
    chk("cnt5", ill_count, 5);
    chk("cnt_sat_w2", ill_count_w2, 3);

`ifdef IMM_GEN_TARGET_EN
    send("tgt_beq", 32'hFE000EE3, 32'h100, 32'hFFFFFFFC, FMT_B);
    chk("tgt_beq_val", out_target, 32'hFC);
    chk("tgt_beq_64", out_target64, 64'hFC);
    send("tgt_auipc", 32'h00001017, 32'h100, 32'h00001000, FMT_U);
    chk("tgt_auipc_val", out_target, 32'h1100);
    send("tgt_addi", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, FMT_I);
    chk("tgt_addi_val", out_target, 32'h0);
`endif

    // Backpressure: four cycles of in_valid against a stalled output.
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", c), in_ready, c < 2);
      in_valid = 1'b1;
      in_instr = (acc == 0) ? 32'h00100093 : 32'h00200093;
      in_pc    = 32'h200 + 32'(acc * 4);
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 2);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_imm", out_imm, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_imm", out_imm, 2);
    chk("bp_second_pc", out_pc, 32'h204);
    chk("bp_ready_back", in_ready, 1);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // Flush with both entries full and in_valid held.
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h0000007F;
    @(negedge clk); in_instr = 32'h00300093;
    @(negedge clk);
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_nothing", out_valid, 0);
    chk("fl_cnt_kept", ill_count, 5);

    // Flush with one entry and a same-cycle accept: both discarded.
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h00400093;
    @(negedge clk); in_instr = 32'h00500093; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid", out_valid, 0);
    @(negedge clk);
    chk("fl2_nothing", out_valid, 0);

    // Asynchronous reset mid-stream.
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h40;
    @(negedge clk); in_valid = 1'b0;
    chk("mr_loaded", out_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_imm", out_imm, 0);
    chk("mr_pc", out_pc, 0);
    chk("mr_fmt", out_fmt, 0);
    chk("mr_cnt", ill_count, 0);
    chk("mr_in_ready", in_ready, 1);
    @(negedge clk) reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
